// File: rtl/cache_nway_wb.sv
`default_nettype none
// ============================================================================
// Module   : cache_nway_wb
// Purpose  : N-way set-associative, write-back, write-allocate cache between
//            the LC-3b CPU port and physical memory. Tree pseudo-LRU victim
//            choice with invalid-way-first, saturating hit/miss counters.
// Revision : 1.0 - initial release
// ============================================================================
module cache_nway_wb #(
  parameter int WAYS       = 4,
  parameter int SETS       = 8,
  parameter int LINE_BYTES = 16,
  parameter int ADDR_W     = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [ADDR_W-1:0]         mem_address,
  input  logic                      mem_read,
  input  logic                      mem_write,
  input  logic [1:0]                mem_byte_enable,
  input  logic [15:0]               mem_wdata,
  output logic [15:0]               mem_rdata,
  output logic                      mem_resp,
  output logic [ADDR_W-1:0]         pmem_address,
  output logic                      pmem_read,
  output logic                      pmem_write,
  output logic [8*LINE_BYTES-1:0]   pmem_wdata,
  input  logic [8*LINE_BYTES-1:0]   pmem_rdata,
  input  logic                      pmem_resp,
  output logic [15:0]               hit_count,
  output logic [15:0]               miss_count
);

  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int LINE_W = 8 * LINE_BYTES;
  localparam int WORD_W = OFF_W - 1;
  localparam int LVL    = $clog2(WAYS);
  localparam int WAY_W  = (WAYS > 1) ? LVL : 1;
  localparam int PLRU_W = (WAYS > 1) ? WAYS - 1 : 1;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITEBACK = 2'd1,
    S_FILL      = 2'd2
  } state_t;

  // Storage arrays
  logic [LINE_W-1:0] data_q  [WAYS][SETS];
  logic [TAG_W-1:0]  tag_q   [WAYS][SETS];
  logic [WAYS-1:0]   valid_q [SETS];
  logic [WAYS-1:0]   dirty_q [SETS];
  logic [PLRU_W-1:0] plru_q  [SETS];

  state_t            state_q, state_d;
  logic [WAY_W-1:0]  victim_q, victim_d;
  logic              fill_done_q, fill_done_d;
  logic [15:0]       hit_cnt_q, miss_cnt_q;

  // Request decode
  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic [WORD_W-1:0] req_word;
  logic              req;
  logic              unused_addr_bit0;

  assign req_tag          = mem_address[ADDR_W-1 -: TAG_W];
  assign req_idx          = mem_address[OFF_W +: IDX_W];
  assign req_word         = mem_address[1 +: WORD_W];
  assign req              = mem_read | mem_write;
  assign unused_addr_bit0 = mem_address[0];

  // Lookup results
  logic [WAYS-1:0]   hit_vec;
  logic              hit;
  logic [WAY_W-1:0]  hit_way;
  logic [LINE_W-1:0] hit_line;
  logic [LINE_W-1:0] merged_line;
  logic [WAY_W-1:0]  miss_victim;
  logic              inv_found;
  logic [WAY_W-1:0]  inv_way;

  // FSM side-effect strobes
  logic access_hit;
  logic count_hit;
  logic count_miss;
  logic wb_done;
  logic fill_write;

  // Walk the tree from the root following the "older" side to reach a leaf.
  function automatic logic [WAY_W-1:0] plru_victim(input logic [PLRU_W-1:0] bits);
    int node;
    node = 0;
    for (int l = 0; l < LVL; l++) begin
      if ((bits & (PLRU_W'(1) << node)) != '0) node = 2 * node + 2;
      else                                      node = 2 * node + 1;
    end
    return WAY_W'(node - (WAYS - 1));
  endfunction

  // Point every node on the accessed way's path away from that way.
  function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] bits,
                                                   input logic [WAY_W-1:0]  way);
    logic [PLRU_W-1:0] b;
    int node;
    int dir;
    b    = bits;
    node = 0;
    for (int l = 0; l < LVL; l++) begin
      dir = (int'(way) >> (LVL - 1 - l)) & 1;
      if (dir == 1) b = b & ~(PLRU_W'(1) << node);
      else          b = b |  (PLRU_W'(1) << node);
      node = 2 * node + 1 + dir;
    end
    return b;
  endfunction

  // Tag compare across all ways of the addressed set and encode the hit way.
  always_comb begin
    hit_vec = '0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      hit_vec[w] = valid_q[req_idx][w] && (tag_q[w][req_idx] == req_tag);
      if (hit_vec[w]) hit_way = WAY_W'(w);
    end
    hit      = |hit_vec;
    hit_line = data_q[hit_way][req_idx];
  end

  // Merge enabled bytes of the CPU write word into the hit line.
  always_comb begin
    merged_line = hit_line;
    if (mem_byte_enable[0]) merged_line[int'(req_word) * 16 +: 8]     = mem_wdata[7:0];
    if (mem_byte_enable[1]) merged_line[int'(req_word) * 16 + 8 +: 8] = mem_wdata[15:8];
  end

  // Victim on a miss: lowest-index invalid way, otherwise the PLRU choice.
  always_comb begin
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[req_idx][w]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
    miss_victim = inv_found ? inv_way : plru_victim(plru_q[req_idx]);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      victim_q    <= '0;
      fill_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      victim_q    <= victim_d;
      fill_done_q <= fill_done_d;
    end
  end

  // FSM next state, handshake outputs and bookkeeping strobes.
  always_comb begin
    state_d      = state_q;
    victim_d     = victim_q;
    fill_done_d  = fill_done_q;
    mem_resp     = 1'b0;
    mem_rdata    = '0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    access_hit   = 1'b0;
    count_hit    = 1'b0;
    count_miss   = 1'b0;
    wb_done      = 1'b0;
    fill_write   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (hit) begin
            mem_resp    = 1'b1;
            if (!mem_write) mem_rdata = hit_line[int'(req_word) * 16 +: 16];
            access_hit  = 1'b1;
            // The completion that follows a line fill belongs to the miss.
            count_hit   = !fill_done_q;
            fill_done_d = 1'b0;
          end else begin
            victim_d   = miss_victim;
            count_miss = 1'b1;
            if (valid_q[req_idx][miss_victim] && dirty_q[req_idx][miss_victim])
              state_d = S_WRITEBACK;
            else
              state_d = S_FILL;
          end
        end
      end
      S_WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_q[victim_q][req_idx], req_idx, {OFF_W{1'b0}}};
        pmem_wdata   = data_q[victim_q][req_idx];
        if (pmem_resp) begin
          wb_done = 1'b1;
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        pmem_read    = 1'b1;
        pmem_address = {req_tag, req_idx, {OFF_W{1'b0}}};
        if (pmem_resp) begin
          fill_write  = 1'b1;
          fill_done_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Valid/dirty/PLRU state and saturating counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      if (count_hit && (hit_cnt_q != 16'hFFFF))   hit_cnt_q  <= hit_cnt_q + 16'd1;
      if (count_miss && (miss_cnt_q != 16'hFFFF)) miss_cnt_q <= miss_cnt_q + 16'd1;
      if (access_hit) begin
        plru_q[req_idx] <= plru_touch(plru_q[req_idx], hit_way);
        if (mem_write) dirty_q[req_idx][hit_way] <= 1'b1;
      end
      if (wb_done) dirty_q[req_idx][victim_q] <= 1'b0;
      if (fill_write) begin
        valid_q[req_idx][victim_q] <= 1'b1;
        dirty_q[req_idx][victim_q] <= 1'b0;
      end
    end
  end

  // Line data and tags; contents are don't-care until the valid bit is set.
  always_ff @(posedge clk) begin
    if (fill_write) begin
      data_q[victim_q][req_idx] <= pmem_rdata;
      tag_q[victim_q][req_idx]  <= req_tag;
    end else if (access_hit && mem_write) begin
      data_q[hit_way][req_idx] <= merged_line;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_cache_nway_wb.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_nway_wb
// Purpose  : Randomised self-checking bench for cache_nway_wb (4 ways, 8 sets,
//            16-byte lines) against a behavioural cache/memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_nway_wb;

  localparam int WAYS = 4;
  localparam int SETS = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [15:0]  mem_address = '0;
  logic         mem_read = 1'b0;
  logic         mem_write = 1'b0;
  logic [1:0]   mem_byte_enable = '0;
  logic [15:0]  mem_wdata = '0;
  logic [15:0]  mem_rdata;
  logic         mem_resp;
  logic [15:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata = '0;
  logic         pmem_resp = 1'b0;
  logic [15:0]  hit_count;
  logic [15:0]  miss_count;

  cache_nway_wb #(.WAYS(4), .SETS(8), .LINE_BYTES(16), .ADDR_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural model: lines per set/way, and per set a list of "which half is older" flags
  logic [127:0] m_line  [SETS][WAYS];
  logic [8:0]   m_tag   [SETS][WAYS];
  bit           m_valid [SETS][WAYS];
  bit           m_dirty [SETS][WAYS];
  bit           m_old   [SETS][WAYS-1];
  logic [127:0] pmem    [int];
  int           m_hits;
  int           m_misses;

  // Last observed pmem transactions of an access
  logic [15:0]  last_wb_addr;
  logic [127:0] last_wb_line;
  logic [15:0]  last_fill_addr;
  logic [15:0]  last_rdata;
  int           last_wb;
  int           last_fill;

  task automatic m_reset();
    for (int s = 0; s < SETS; s++) begin
      for (int w = 0; w < WAYS; w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
      end
      for (int n = 0; n < WAYS - 1; n++) m_old[s][n] = 1'b0;
    end
    m_hits   = 0;
    m_misses = 0;
  endtask

  // Halve the way range repeatedly, moving into whichever half is marked older.
  function automatic int m_pick_old(input int s);
    int lo, hi, node, mid;
    lo = 0; hi = WAYS; node = 0;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (m_old[s][node]) begin lo = mid; node = 2 * node + 2; end
      else                begin hi = mid; node = 2 * node + 1; end
    end
    return lo;
  endfunction

  // Mark the half not containing way w as older at every level.
  task automatic m_touch(input int s, input int w);
    int lo, hi, node, mid;
    lo = 0; hi = WAYS; node = 0;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (w < mid) begin m_old[s][node] = 1'b1; hi = mid; node = 2 * node + 1; end
      else         begin m_old[s][node] = 1'b0; lo = mid; node = 2 * node + 2; end
    end
  endtask

  function automatic logic [127:0] get_line(input logic [15:0] a);
    if (!pmem.exists(int'(a))) pmem[int'(a)] = {$urandom, $urandom, $urandom, $urandom};
    return pmem[int'(a)];
  endfunction

  // One CPU access: update the model, drive the request, act as memory, check.
  task automatic access(input logic [15:0] a, input bit wr, input bit rd_too,
                        input logic [1:0] be, input logic [15:0] wd, input string nm);
    int s, wi, w, v, cyc, wait_n;
    logic [8:0]   t;
    bit           exp_hit, exp_wb, done;
    logic [15:0]  exp_wb_addr, exp_fill_addr, exp_rd;
    logic [127:0] exp_wb_line;
    t  = a[15:7];
    s  = int'(a[6:4]);
    wi = int'(a[3:1]);
    w  = -1;
    for (int k = 0; k < WAYS; k++) if (m_valid[s][k] && m_tag[s][k] == t) w = k;
    exp_hit = (w >= 0);
    exp_wb = 1'b0; exp_wb_addr = '0; exp_wb_line = '0; exp_fill_addr = '0;
    if (exp_hit) begin
      if (m_hits < 65535) m_hits++;
    end else begin
      if (m_misses < 65535) m_misses++;
      v = -1;
      for (int k = WAYS - 1; k >= 0; k--) if (!m_valid[s][k]) v = k;
      if (v < 0) v = m_pick_old(s);
      if (m_valid[s][v] && m_dirty[s][v]) begin
        exp_wb      = 1'b1;
        exp_wb_addr = {m_tag[s][v], a[6:4], 4'h0};
        exp_wb_line = m_line[s][v];
        pmem[int'(exp_wb_addr)] = exp_wb_line;
      end
      exp_fill_addr = {t, a[6:4], 4'h0};
      m_line[s][v]  = get_line(exp_fill_addr);
      m_tag[s][v]   = t;
      m_valid[s][v] = 1'b1;
      m_dirty[s][v] = 1'b0;
      w = v;
    end
    m_touch(s, w);
    if (wr) begin
      if (be[0]) m_line[s][w][wi * 16 +: 8]     = wd[7:0];
      if (be[1]) m_line[s][w][wi * 16 + 8 +: 8] = wd[15:8];
      m_dirty[s][w] = 1'b1;
    end
    exp_rd = m_line[s][w][wi * 16 +: 16];

    mem_address = a; mem_write = wr; mem_read = !wr || rd_too;
    mem_byte_enable = be; mem_wdata = wd;
    last_wb = 0; last_fill = 0; cyc = 0; done = 1'b0; wait_n = 0; last_rdata = '0;
    while (!done && cyc < 400) begin
      #1;
      if (mem_resp) begin
        last_rdata = mem_rdata;
        done = 1'b1;
      end else if (pmem_write || pmem_read) begin
        if (wait_n == 0) begin
          if (pmem_write) begin
            last_wb++;
            last_wb_addr = pmem_address;
            last_wb_line = pmem_wdata;
            chk_val({nm, "_wb_addr"}, 128'(pmem_address), 128'(exp_wb_addr));
            chk_val({nm, "_wb_data"}, pmem_wdata, exp_wb_line);
          end else begin
            last_fill++;
            last_fill_addr = pmem_address;
            chk_val({nm, "_fill_addr"}, 128'(pmem_address), 128'(exp_fill_addr));
          end
          wait_n = $urandom_range(1, 5);
        end
        wait_n--;
        if (wait_n == 0) begin
          if (pmem_read) pmem_rdata = get_line(pmem_address);
          pmem_resp = 1'b1;
        end
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
      pmem_resp = 1'b0;
    end
    mem_read = 1'b0; mem_write = 1'b0;
    chk_val({nm, "_done"}, 128'(done), 128'(1));
    chk_val({nm, "_hit"}, 128'(last_wb == 0 && last_fill == 0 && cyc == 1), 128'(exp_hit));
    chk_val({nm, "_nwb"}, 128'(last_wb), 128'(exp_wb));
    chk_val({nm, "_nfill"}, 128'(last_fill), 128'(!exp_hit));
    if (!wr) chk_val({nm, "_rdata"}, 128'(last_rdata), 128'(exp_rd));
    chk_val({nm, "_hitcnt"}, 128'(hit_count), 128'(m_hits));
    chk_val({nm, "_misscnt"}, 128'(miss_count), 128'(m_misses));
  endtask

  task automatic check_idle_outputs(input string nm);
    chk_val({nm, "_resp"}, 128'(mem_resp), 128'(0));
    chk_val({nm, "_rdata"}, 128'(mem_rdata), 128'(0));
    chk_val({nm, "_pread"}, 128'(pmem_read), 128'(0));
    chk_val({nm, "_pwrite"}, 128'(pmem_write), 128'(0));
    chk_val({nm, "_paddr"}, 128'(pmem_address), 128'(0));
    chk_val({nm, "_hitcnt"}, 128'(hit_count), 128'(0));
    chk_val({nm, "_misscnt"}, 128'(miss_count), 128'(0));
  endtask

  logic [15:0] ra;
  int          cyc_w;

  initial begin
    m_reset();
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // 1: cold read, then reread hits
    pmem[16'h1230] = 128'h0123_4567_89AB_CDEF_1111_BEEF_2222_3333;
    access(16'h1234, 1'b0, 1'b0, 2'b00, 16'h0, "t1_cold");
    chk_val("t1_beef", 128'(last_rdata), 128'(16'hBEEF));
    chk_val("t1_faddr", 128'(last_fill_addr), 128'(16'h1230));
    chk_val("t1_miss1", 128'(miss_count), 128'(1));
    access(16'h1234, 1'b0, 1'b0, 2'b00, 16'h0, "t1_reread");
    chk_val("t1_hit1", 128'(hit_count), 128'(1));

    // 2: low-byte write hit
    access(16'h1234, 1'b1, 1'b0, 2'b01, 16'hAA55, "t2_write");
    access(16'h1234, 1'b0, 1'b0, 2'b00, 16'h0, "t2_read");
    chk_val("t2_merged", 128'(last_rdata), 128'(16'hBE55));

    // 3: fill set 3, touch two ways, clean eviction of the tag 0x25 line
    access(16'h12B0, 1'b0, 1'b0, 2'b00, 16'h0, "t3_f25");
    access(16'h1330, 1'b0, 1'b0, 2'b00, 16'h0, "t3_f26");
    access(16'h13B0, 1'b0, 1'b0, 2'b00, 16'h0, "t3_f27");
    access(16'h1230, 1'b0, 1'b0, 2'b00, 16'h0, "t3_t24");
    access(16'h1330, 1'b0, 1'b0, 2'b00, 16'h0, "t3_t26");
    access(16'h1430, 1'b0, 1'b0, 2'b00, 16'h0, "t3_m28");
    chk_val("t3_clean", 128'(last_wb), 128'(0));

    // 4: steer PLRU onto the dirty tag 0x24 line and evict it
    access(16'h1430, 1'b0, 1'b0, 2'b00, 16'h0, "t4_t28");
    access(16'h13B0, 1'b0, 1'b0, 2'b00, 16'h0, "t4_t27");
    access(16'h14B0, 1'b0, 1'b0, 2'b00, 16'h0, "t4_m29");
    chk_val("t4_wbaddr", 128'(last_wb_addr), 128'(16'h1230));
    chk_val("t4_wbword", 128'(last_wb_line[47:32]), 128'(16'hBE55));
    chk_val("t4_faddr", 128'(last_fill_addr), 128'(16'h14B0));

    // Randomised traffic concentrated on two sets to force evictions
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) < 8)
        ra = {9'($urandom_range(0, 7)), 3'($urandom_range(0, 1)), 4'($urandom_range(0, 15))};
      else
        ra = 16'($urandom);
      access(ra, ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
             2'($urandom_range(0, 3)), 16'($urandom), "rnd");
    end

    // 5: reset, then reset again in the middle of a fill
    rst_n = 1'b0;
    m_reset();
    #1;
    check_idle_outputs("rst2");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mem_address = 16'h1234; mem_read = 1'b1;
    cyc_w = 0;
    while (!pmem_read && cyc_w < 20) begin
      @(posedge clk);
      @(negedge clk);
      cyc_w++;
    end
    chk_val("t5_fill_seen", 128'(pmem_read), 128'(1));
    #2 rst_n = 1'b0;
    #1;
    check_idle_outputs("t5_midfill");
    mem_read = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    access(16'h1234, 1'b0, 1'b0, 2'b00, 16'h0, "t5_reissue");
    chk_val("t5_missed", 128'(last_fill), 128'(1));

    // 6: hold a hitting read long enough to saturate the hit counter
    mem_address = 16'h1234; mem_read = 1'b1;
    repeat (65540) @(posedge clk);
    @(negedge clk);
    chk_val("t6_resp", 128'(mem_resp), 128'(1));
    chk_val("t6_sat", 128'(hit_count), 128'(16'hFFFF));
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk_val("t6_nowrap", 128'(hit_count), 128'(16'hFFFF));
    chk_val("t6_miss", 128'(miss_count), 128'(1));
    mem_read = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
